// File: rtl/regfile_writeback_queue_pkg.sv
// Shared widths and entry types for the register-file writeback queue.
// Imported by the interface, the FIFO and the top.
package wbq_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rc;
    logic [DATA_W-1:0]     dc;
  } wb_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } wb_fwd_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer-side valid/ready write channel into the writeback queue.
// Producers use master; the queue uses slave.
interface wbq_if;
  import wbq_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rc;
  logic [DATA_W-1:0]     in_dc;

  modport master (
    output in_valid,
    output in_rc,
    output in_dc,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_rc,
    input  in_dc,
    output in_ready
  );

endinterface

// File: rtl/regfile_writeback_queue_fifo.sv
// Circular buffer of pending register writes.
// Entries are also exposed oldest-first so the top can forward from them.
module wbq_fifo
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t ent [DEPTH],
  output logic [DEPTH-1:0] ent_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Age-ordered view: slot 0 is the head, slot count-1 the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i]     = mem_q[head_q + PTR_W'(i)];
      ent_vld[i] = CNT_W'(i) < count_q;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the register file write port:
// buffers producer writes, retires one per cycle, forwards pending data.
module regfile_writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  wbq_if.slave                  wr,
  input  logic                  hold,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rc,
  output logic [DATA_W-1:0]     dc,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  output logic                  fwd_a_hit,
  output logic [DATA_W-1:0]     fwd_a_data,
  output logic                  fwd_b_hit,
  output logic [DATA_W-1:0]     fwd_b_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  wb_entry_t        in_entry;

  logic fire, push_ok, empty, bypass, pop, enq;

  logic      regwrite_q, regwrite_d;
  wb_entry_t out_q, out_d;

  wb_fwd_t fwd_a, fwd_b;

  assign in_entry = '{rc: wr.in_rc, dc: wr.in_dc};
  assign wr.in_ready = (fifo_count != CNT_W'(DEPTH));

  // Writes to r0 complete the handshake but are dropped here.
  assign fire    = wr.in_valid && wr.in_ready;
  assign push_ok = fire && (wr.in_rc != ZERO_REG);
  assign empty   = (fifo_count == '0);
  assign pop     = !hold && !empty;
  assign bypass  = !hold && empty && push_ok;
  assign enq     = push_ok && !bypass;

  wbq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (enq),
    .push_entry(in_entry),
    .pop       (pop),
    .count     (fifo_count),
    .ent       (ent),
    .ent_vld   (ent_vld)
  );

  always_comb begin
    regwrite_d = 1'b0;
    out_d      = out_q;
    unique case (1'b1)
      pop: begin
        regwrite_d = 1'b1;
        out_d      = ent[0];
      end
      bypass: begin
        regwrite_d = 1'b1;
        out_d      = in_entry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      out_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      out_q      <= out_d;
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (regwrite_q && out_q.rc == ra) begin
      fwd_a = '{hit: 1'b1, data: out_q.dc};
    end
    if (regwrite_q && out_q.rc == rb) begin
      fwd_b = '{hit: 1'b1, data: out_q.dc};
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent[i].rc == ra) begin
        fwd_a = '{hit: 1'b1, data: ent[i].dc};
      end
      if (ent_vld[i] && ent[i].rc == rb) begin
        fwd_b = '{hit: 1'b1, data: ent[i].dc};
      end
    end
    if (ra == ZERO_REG) begin
      fwd_a = '0;
    end
    if (rb == ZERO_REG) begin
      fwd_b = '0;
    end
  end

  assign RegWrite   = regwrite_q;
  assign rc         = out_q.rc;
  assign dc         = out_q.dc;
  assign fwd_a_hit  = fwd_a.hit;
  assign fwd_a_data = fwd_a.data;
  assign fwd_b_hit  = fwd_b.hit;
  assign fwd_b_data = fwd_b.data;
  assign count      = fifo_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue.
// Each task drives one scenario and checks its own results.
module tb_regfile_writeback_queue;
  import wbq_pkg::*;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        RegWrite;
  logic [4:0]  rc;
  logic [31:0] dc;
  logic [4:0]  ra, rb;
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_a_data, fwd_b_data;
  logic [2:0]  count;

  int checks;
  int errors;

  wbq_if wif ();

  regfile_writeback_queue #(
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wif),
    .hold      (hold),
    .RegWrite  (RegWrite),
    .rc        (rc),
    .dc        (dc),
    .ra        (ra),
    .rb        (rb),
    .fwd_a_hit (fwd_a_hit),
    .fwd_a_data(fwd_a_data),
    .fwd_b_hit (fwd_b_hit),
    .fwd_b_data(fwd_b_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    hold = 1'b0;
    wif.in_valid = 1'b0;
    wif.in_rc = '0;
    wif.in_dc = '0;
    ra = '0;
    rb = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (RegWrite !== 1'b0 || count !== 3'd0 || wif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: RegWrite=%b count=%0d in_ready=%b required 0 0 1",
               RegWrite, count, wif.in_ready);
    end
    checks++;
    if (rc !== 5'd0 || dc !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: rc=%0d dc=%h required 0 0", rc, dc);
    end
    hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wif.in_valid = 1'b1;
      wif.in_rc = 5'(i);
      wif.in_dc = 32'(i);
      tick();
    end
    wif.in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d required 3", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || count !== 3'd0 || wif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: RegWrite=%b count=%0d in_ready=%b required 0 0 1",
               RegWrite, count, wif.in_ready);
    end
    tick();
    reset = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (RegWrite !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL reset_no_retire: cycle %0d RegWrite=%b count=%0d required 0 0",
                 i, RegWrite, count);
      end
    end
  endtask

  task automatic test_bypass;
    hold = 1'b0;
    wif.in_valid = 1'b1;
    wif.in_rc = 5'd5;
    wif.in_dc = 32'hDEADBEEF;
    tick();
    wif.in_valid = 1'b0;
    checks++;
    if (RegWrite !== 1'b1 || rc !== 5'd5 || dc !== 32'hDEADBEEF || count !== 3'd0) begin
      errors++;
      $display("FAIL bypass: RegWrite=%b rc=%0d dc=%h count=%0d required 1 5 deadbeef 0",
               RegWrite, rc, dc, count);
    end
    tick();
    checks++;
    if (RegWrite !== 1'b0 || rc !== 5'd5) begin
      errors++;
      $display("FAIL bypass_pulse: RegWrite=%b rc=%0d required 0 5", RegWrite, rc);
    end
  endtask

  task automatic test_full;
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wif.in_valid = 1'b1;
      wif.in_rc = 5'(i);
      wif.in_dc = 32'h100 + 32'(i);
      tick();
      checks++;
      if (count !== 3'(i) || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL fill: step %0d count=%0d RegWrite=%b required %0d 0",
                 i, count, RegWrite, i);
      end
    end
    checks++;
    if (wif.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: in_ready=%b required 0", wif.in_ready);
    end
    wif.in_rc = 5'd9;
    wif.in_dc = 32'h999;
    tick();
    wif.in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_reject: count=%0d required 4", count);
    end
    ra = 5'd3;
    rb = 5'd9;
    #1;
    checks++;
    if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'h103 || fwd_b_hit !== 1'b0) begin
      errors++;
      $display("FAIL full_fwd: a_hit=%b a_data=%h b_hit=%b required 1 103 0",
               fwd_a_hit, fwd_a_data, fwd_b_hit);
    end
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (RegWrite !== 1'b1 || rc !== 5'(k) || dc !== 32'h100 + 32'(k)
          || count !== 3'(4 - k)) begin
        errors++;
        $display("FAIL drain: step %0d RegWrite=%b rc=%0d dc=%h count=%0d",
                 k, RegWrite, rc, dc, count);
      end
    end
    tick();
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: RegWrite=%b required 0", RegWrite);
    end
  endtask

  task automatic test_forward;
    hold = 1'b1;
    wif.in_valid = 1'b1;
    wif.in_rc = 5'd7;
    wif.in_dc = 32'h11;
    tick();
    wif.in_dc = 32'h22;
    tick();
    wif.in_valid = 1'b0;
    ra = 5'd7;
    rb = 5'd7;
    #1;
    checks++;
    if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'h22
        || fwd_b_hit !== 1'b1 || fwd_b_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_youngest: a=%b/%h b=%b/%h required 1/22 1/22",
               fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data);
    end
    ra = 5'd0;
    #1;
    checks++;
    if (fwd_a_hit !== 1'b0 || fwd_a_data !== 32'd0) begin
      errors++;
      $display("FAIL fwd_zero: hit=%b data=%h required 0 0", fwd_a_hit, fwd_a_data);
    end
    ra = 5'd7;
    hold = 1'b0;
    tick();
    checks++;
    if (RegWrite !== 1'b1 || dc !== 32'h11 || fwd_a_hit !== 1'b1
        || fwd_a_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_fifo_over_out: RegWrite=%b dc=%h hit=%b data=%h required 1 11 1 22",
               RegWrite, dc, fwd_a_hit, fwd_a_data);
    end
    tick();
    checks++;
    if (RegWrite !== 1'b1 || fwd_a_hit !== 1'b1 || fwd_a_data !== 32'h22) begin
      errors++;
      $display("FAIL fwd_out_stage: RegWrite=%b hit=%b data=%h required 1 1 22",
               RegWrite, fwd_a_hit, fwd_a_data);
    end
    tick();
    checks++;
    if (fwd_a_hit !== 1'b0 || fwd_a_data !== 32'd0) begin
      errors++;
      $display("FAIL fwd_idle: hit=%b data=%h required 0 0", fwd_a_hit, fwd_a_data);
    end
    ra = '0;
    rb = '0;
  endtask

  task automatic test_zero_reg;
    for (int h = 0; h < 2; h++) begin
      hold = h[0];
      wif.in_valid = 1'b1;
      wif.in_rc = 5'd0;
      wif.in_dc = 32'hFFFF;
      #1;
      checks++;
      if (wif.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_ready: hold=%0d in_ready=%b required 1", h, wif.in_ready);
      end
      tick();
      wif.in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL zero_drop: hold=%0d count=%0d RegWrite=%b required 0 0",
                 h, count, RegWrite);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_wrap;
    logic [4:0]  q_rc [$];
    logic [31:0] q_dc [$];
    logic [4:0]  exp_rc;
    logic [31:0] exp_dc;
    logic        exp_rw, h, v, exp_ready, fire;
    logic [4:0]  r;
    logic [31:0] d;
    int pushed, retired, cyc;
    pushed = 0;
    retired = 0;
    cyc = 0;
    exp_rc = '0;
    exp_dc = '0;
    while ((pushed < 20 || q_rc.size() > 0) && cyc < 300) begin
      cyc++;
      h = 1'($urandom_range(0, 1));
      v = (pushed < 20) && ($urandom_range(0, 3) != 0);
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      hold = h;
      wif.in_valid = v;
      wif.in_rc = r;
      wif.in_dc = d;
      exp_ready = (q_rc.size() != 4);
      checks++;
      if (wif.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL wrap_ready: cycle %0d in_ready=%b required %b",
                 cyc, wif.in_ready, exp_ready);
      end
      fire = v && exp_ready;
      exp_rw = 1'b0;
      if (!h && q_rc.size() > 0) begin
        exp_rw = 1'b1;
        exp_rc = q_rc.pop_front();
        exp_dc = q_dc.pop_front();
        if (fire) begin
          q_rc.push_back(r);
          q_dc.push_back(d);
        end
      end else if (!h && fire) begin
        exp_rw = 1'b1;
        exp_rc = r;
        exp_dc = d;
      end else if (fire) begin
        q_rc.push_back(r);
        q_dc.push_back(d);
      end
      if (fire) pushed++;
      tick();
      checks++;
      if (RegWrite !== exp_rw || (exp_rw && (rc !== exp_rc || dc !== exp_dc))) begin
        errors++;
        $display("FAIL wrap_retire: cycle %0d RegWrite=%b rc=%0d dc=%h required %b %0d %h",
                 cyc, RegWrite, rc, dc, exp_rw, exp_rc, exp_dc);
      end
      if (exp_rw) retired++;
      checks++;
      if (count !== 3'(q_rc.size()) || count > 3'd4) begin
        errors++;
        $display("FAIL wrap_count: cycle %0d count=%0d required %0d",
                 cyc, count, q_rc.size());
      end
    end
    wif.in_valid = 1'b0;
    hold = 1'b0;
    checks++;
    if (retired != 20) begin
      errors++;
      $display("FAIL wrap_total: retired=%0d required 20", retired);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_full();
    test_forward();
    test_zero_reg();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
